// File: rtl/pulse_shot_sched.sv
// Shot scheduler: stages one parameter set, promotes it to the pulse engine on
// period boundaries, and sequences a programmed number of shots.
module pulse_shot_sched #(
    parameter int PER_W = 32,
    parameter int WID_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PER_W-1:0] cfg_per,
    input  logic [WID_W-1:0] cfg_p1wid,
    input  logic [WID_W-1:0] cfg_del,
    input  logic [WID_W-1:0] cfg_p2wid,
    input  logic [CNT_W-1:0] cfg_nshots,
    input  logic             start,
    input  logic             abort,
    output logic [PER_W-1:0] per_o,
    output logic [WID_W-1:0] p1wid_o,
    output logic [WID_W-1:0] del_o,
    output logic [WID_W-1:0] p2wid_o,
    output logic             shot_start,
    output logic [CNT_W-1:0] shot_idx,
    output logic             busy,
    output logic             done,
    output logic             err_cfg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [PER_W-1:0] r_pcnt;
    logic [CNT_W-1:0] r_idx;
    logic             r_shot_start;
    logic             r_abort_pend;
    logic             r_err;

    logic             r_stg_full;
    logic [PER_W-1:0] r_stg_per;
    logic [WID_W-1:0] r_stg_p1;
    logic [WID_W-1:0] r_stg_del;
    logic [WID_W-1:0] r_stg_p2;
    logic [CNT_W-1:0] r_stg_n;

    logic [PER_W-1:0] r_per;
    logic [WID_W-1:0] r_p1;
    logic [WID_W-1:0] r_del;
    logic [WID_W-1:0] r_p2;
    logic [CNT_W-1:0] r_n;

    logic [PER_W:0]   w_sum;
    logic             w_legal;
    logic             w_capture;
    logic             w_bnd;
    logic             w_last;
    logic             w_promote;

    // One extra bit on the sum keeps the legality compare overflow-free.
    assign w_sum     = (PER_W+1)'(cfg_p1wid) + (PER_W+1)'(cfg_del) + (PER_W+1)'(cfg_p2wid);
    assign w_legal   = (cfg_per >= PER_W'(2)) && ({1'b0, cfg_per} > w_sum);
    assign w_capture = cfg_valid && !r_stg_full;
    assign w_bnd     = (r_state == S_RUN) && (r_pcnt == r_per - PER_W'(1));
    assign w_last    = ((r_n != '0) && (r_idx == r_n - CNT_W'(1))) || r_abort_pend;
    // A boundary that ends the run leaves staging pending until back in IDLE.
    assign w_promote = r_stg_full && ((r_state == S_IDLE) || (w_bnd && !w_last));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg_full <= 1'b0;
            r_stg_per  <= '0;
            r_stg_p1   <= '0;
            r_stg_del  <= '0;
            r_stg_p2   <= '0;
            r_stg_n    <= '0;
            r_per      <= '0;
            r_p1       <= '0;
            r_del      <= '0;
            r_p2       <= '0;
            r_n        <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_promote) begin
                r_per      <= r_stg_per;
                r_p1       <= r_stg_p1;
                r_del      <= r_stg_del;
                r_p2       <= r_stg_p2;
                r_n        <= r_stg_n;
                r_stg_full <= 1'b0;
            end else if (w_capture && w_legal) begin
                r_stg_per  <= cfg_per;
                r_stg_p1   <= cfg_p1wid;
                r_stg_del  <= cfg_del;
                r_stg_p2   <= cfg_p2wid;
                r_stg_n    <= cfg_nshots;
                r_stg_full <= 1'b1;
            end
            if (w_capture) begin
                r_err <= !w_legal;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pcnt       <= '0;
            r_idx        <= '0;
            r_shot_start <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_shot_start <= 1'b0;
                    if (start && (r_per != '0)) begin
                        r_state      <= S_RUN;
                        r_pcnt       <= '0;
                        r_idx        <= '0;
                        r_shot_start <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (w_bnd) begin
                        if (w_last) begin
                            r_state      <= S_DONE;
                            r_abort_pend <= 1'b0;
                            r_shot_start <= 1'b0;
                        end else begin
                            r_pcnt       <= '0;
                            r_idx        <= r_idx + CNT_W'(1);
                            r_shot_start <= 1'b1;
                        end
                    end else begin
                        r_pcnt       <= r_pcnt + PER_W'(1);
                        r_shot_start <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state      <= S_IDLE;
                    r_shot_start <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_shot_start <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready  = !r_stg_full;
    assign per_o      = r_per;
    assign p1wid_o    = r_p1;
    assign del_o      = r_del;
    assign p2wid_o    = r_p2;
    assign shot_start = r_shot_start;
    assign shot_idx   = r_idx;
    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign err_cfg    = r_err;

endmodule

// File: tb/tb_pulse_shot_sched.sv
// Bench for pulse_shot_sched: directed scenarios plus randomized configs/runs,
// with expected timing derived arithmetically from period and shot count.
module tb_pulse_shot_sched;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_per;
    logic [15:0] cfg_p1wid;
    logic [15:0] cfg_del;
    logic [15:0] cfg_p2wid;
    logic [15:0] cfg_nshots;
    logic        start;
    logic        abort;
    logic [31:0] per_o;
    logic [15:0] p1wid_o;
    logic [15:0] del_o;
    logic [15:0] p2wid_o;
    logic        shot_start;
    logic [15:0] shot_idx;
    logic        busy;
    logic        done;
    logic        err_cfg;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned exp_per = 0;

    pulse_shot_sched #(.PER_W(32), .WID_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_per(cfg_per), .cfg_p1wid(cfg_p1wid), .cfg_del(cfg_del),
        .cfg_p2wid(cfg_p2wid), .cfg_nshots(cfg_nshots), .start(start),
        .abort(abort), .per_o(per_o), .p1wid_o(p1wid_o), .del_o(del_o),
        .p2wid_o(p2wid_o), .shot_start(shot_start), .shot_idx(shot_idx),
        .busy(busy), .done(done), .err_cfg(err_cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, 64'(cfg_ready), 64'(1));
        chk({tag, "_per"}, 64'(per_o), 64'(0));
        chk({tag, "_p1"}, 64'(p1wid_o), 64'(0));
        chk({tag, "_del"}, 64'(del_o), 64'(0));
        chk({tag, "_p2"}, 64'(p2wid_o), 64'(0));
        chk({tag, "_strobe"}, 64'(shot_start), 64'(0));
        chk({tag, "_idx"}, 64'(shot_idx), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_err"}, 64'(err_cfg), 64'(0));
    endtask

    // Offer one set while idle; legality judged from the sum rule.
    task automatic offer(input int unsigned per, input int unsigned p1, input int unsigned dl,
                         input int unsigned p2, input int unsigned n);
        bit legal;
        legal = (per >= 2) && (per > p1 + dl + p2);
        chk("ready_pre", 64'(cfg_ready), 64'(1));
        cfg_valid  = 1'b1;
        cfg_per    = 32'(per);
        cfg_p1wid  = 16'(p1);
        cfg_del    = 16'(dl);
        cfg_p2wid  = 16'(p2);
        cfg_nshots = 16'(n);
        step();
        cfg_valid = 1'b0;
        chk("err_cfg", 64'(err_cfg), 64'(!legal));
        chk("ready_cap", 64'(cfg_ready), 64'(!legal));
        chk("per_hold", 64'(per_o), 64'(exp_per));
        step();
        if (legal) exp_per = per;
        chk("per_o", 64'(per_o), 64'(exp_per));
        chk("ready_post", 64'(cfg_ready), 64'(1));
        if (legal) begin
            chk("p1wid_o", 64'(p1wid_o), 64'(p1));
            chk("del_o", 64'(del_o), 64'(dl));
            chk("p2wid_o", 64'(p2wid_o), 64'(p2));
        end
    endtask

    // Start a run expected to emit 'shots' shots of length 'per'; abort is
    // pulsed for one cycle at relative cycle abort_rel (0 = never).
    task automatic run_expect(input int unsigned per, input int unsigned shots,
                              input int unsigned abort_rel);
        int unsigned strobes;
        bit in_run;
        strobes = 0;
        chk("busy_pre", 64'(busy), 64'(0));
        start = 1'b1;
        step();
        start = 1'b0;
        for (int unsigned rel = 1; rel <= shots * per + 2; rel++) begin
            in_run = (rel <= shots * per);
            if (shot_start === 1'b1) strobes++;
            chk("shot_start", 64'(shot_start), 64'(in_run && ((rel - 1) % per == 0)));
            chk("busy", 64'(busy), 64'(in_run));
            chk("done", 64'(done), 64'(rel == shots * per + 1));
            chk("shot_idx", 64'(shot_idx), 64'(in_run ? (rel - 1) / per : shots - 1));
            abort = (rel == abort_rel);
            step();
        end
        abort = 1'b0;
        chk("strobe_count", 64'(strobes), 64'(shots));
    endtask

    initial begin
        int unsigned per, p1, dl, p2, n, s, off;
        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_per    = '0;
        cfg_p1wid  = '0;
        cfg_del    = '0;
        cfg_p2wid  = '0;
        cfg_nshots = '0;
        start      = 1'b0;
        abort      = 1'b0;
        step();
        step();
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        step();
        chk_idle_outputs("post_reset");

        // start ignored while nothing has been promoted
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("start_per0_busy", 64'(busy), 64'(0));
            chk("start_per0_strobe", 64'(shot_start), 64'(0));
        end
        start = 1'b0;
        step();

        offer(10, 2, 3, 2, 3);
        run_expect(10, 3, 0);

        // re-program mid-shot 0: promotion waits for the boundary
        start = 1'b1;
        step();
        start = 1'b0;
        for (int unsigned rel = 1; rel <= 52; rel++) begin
            chk("rp_strobe", 64'(shot_start), 64'(rel == 1 || rel == 11 || rel == 31));
            chk("rp_busy", 64'(busy), 64'(rel <= 50));
            chk("rp_done", 64'(done), 64'(rel == 51));
            chk("rp_per", 64'(per_o), 64'(rel <= 10 ? 10 : 20));
            chk("rp_ready", 64'(cfg_ready), 64'(!(rel >= 4 && rel <= 10)));
            chk("rp_idx", 64'(shot_idx), 64'(rel <= 10 ? 0 : (rel <= 30 ? 1 : 2)));
            cfg_valid = (rel == 3);
            if (rel == 3) begin
                cfg_per    = 32'd20;
                cfg_p1wid  = 16'd2;
                cfg_del    = 16'd3;
                cfg_p2wid  = 16'd2;
                cfg_nshots = 16'd3;
            end
            step();
        end
        exp_per = 20;

        offer(5, 2, 2, 1, 3);
        offer(10, 2, 3, 2, 0);
        run_expect(10, 3, 1 + 2 * 10 + 4);

        // abort while idle has no lasting effect
        abort = 1'b1;
        step();
        abort = 1'b0;
        offer(6, 1, 1, 1, 2);
        run_expect(6, 2, 0);

        for (int it = 0; it < 10; it++) begin
            per = $urandom_range(12, 2);
            p1  = $urandom_range(4, 0);
            dl  = $urandom_range(4, 0);
            p2  = $urandom_range(4, 0);
            n   = $urandom_range(3, 0);
            offer(per, p1, dl, p2, n);
            if ((per > p1 + dl + p2) && n != 0) begin
                run_expect(per, n, 0);
            end else if (per > p1 + dl + p2) begin
                s   = $urandom_range(2, 0);
                off = $urandom_range(per - 1, 0);
                run_expect(per, s + 1 + ((off == per - 1) ? 1 : 0), 1 + s * per + off);
            end
        end

        // asynchronous reset mid-run
        offer(8, 1, 2, 3, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre_rst_busy", 64'(busy), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        step();
        chk("rst_hold_done", 64'(done), 64'(0));
        rst_n = 1'b1;
        exp_per = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("after_rst_done", 64'(done), 64'(0));
            chk("after_rst_busy", 64'(busy), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
